// File: rtl/stage_scoreboard_pkg.sv
// Shared game definitions: stage states, default timing/money limits, bus widths
// and the saturating money adder.
package stage_scoreboard_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUNNING = 2'd1,
      ST_PASSED  = 2'd2,
      ST_FAILED  = 2'd3
   } stage_state_t;

   localparam int DEF_MAX_TIME  = 60;
   localparam int DEF_LOW_TIME  = 10;
   localparam int DEF_MONEY_MAX = 9999;

   localparam int TIME_W  = 7;
   localparam int MONEY_W = 14;
   localparam int VALUE_W = 10;
   localparam int SUM_W   = MONEY_W + 1;

   // Sum is formed one bit wider than money so the ceiling compare never sees a wrap.
   function automatic logic [MONEY_W-1:0] sat_add(input logic [MONEY_W-1:0] base,
                                                  input logic [VALUE_W-1:0] value,
                                                  input int                 ceiling);
      logic [SUM_W-1:0] sum;
      sum = {1'b0, base} + {{(SUM_W-VALUE_W){1'b0}}, value};
      if (sum > SUM_W'(ceiling))
         return MONEY_W'(ceiling);
      return sum[MONEY_W-1:0];
   endfunction

endpackage

// File: rtl/stage_scoreboard_if.sv
// Stage control/status bundle between the level controller and the scoreboard.
interface stage_scoreboard_if;
   import stage_scoreboard_pkg::*;

   logic               enable;
   logic               newGame;
   logic               oneSecPulse;
   logic               collectValid;
   logic [VALUE_W-1:0] collectValue;
   logic [MONEY_W-1:0] targetMoney;
   logic [TIME_W-1:0]  timeLeft;
   logic [MONEY_W-1:0] money;
   logic               timeLow;
   logic               stagePassed;
   logic               stageFailed;
   logic               running;

   modport master (
      output enable, newGame, oneSecPulse, collectValid, collectValue, targetMoney,
      input  timeLeft, money, timeLow, stagePassed, stageFailed, running
   );

   modport slave (
      input  enable, newGame, oneSecPulse, collectValid, collectValue, targetMoney,
      output timeLeft, money, timeLow, stagePassed, stageFailed, running
   );

endinterface

// File: rtl/stage_scoreboard_sec_countdown.sv
// Seconds down-counter: clear > load > tick; stops at zero.
// expire flags the tick that takes the count from 1 to 0.
module sec_countdown
   import stage_scoreboard_pkg::*;
(
   input  logic              clk,
   input  logic              resetN,
   input  logic              clear,
   input  logic              load,
   input  logic [TIME_W-1:0] load_value,
   input  logic              tick,
   output logic [TIME_W-1:0] count,
   output logic [TIME_W-1:0] count_nxt,
   output logic              expire
);

   // next count; the zero check keeps the counter from wrapping
   always_comb begin
      count_nxt = count;
      if (clear)
         count_nxt = '0;
      else if (load)
         count_nxt = load_value;
      else if (tick && (count != '0))
         count_nxt = count - TIME_W'(1);
   end

   assign expire = tick && !clear && !load && (count == TIME_W'(1));

   // count register
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)
         count <= '0;
      else
         count <= count_nxt;
   end

endmodule

// File: rtl/stage_scoreboard.sv
// Stage scoreboard: runs one timed stage, accumulates collected money and
// reports pass/fail against the target sampled at stage start.
//
//   state       | meaning
//   ST_IDLE     | waiting for an enable rising edge
//   ST_RUNNING  | countdown active, collects accepted
//   ST_PASSED   | time ran out with money >= target; hold until enable low
//   ST_FAILED   | time ran out with money <  target; hold until enable low
module stage_scoreboard
   import stage_scoreboard_pkg::*;
#(
   parameter int MAX_TIME  = DEF_MAX_TIME,
   parameter int LOW_TIME  = DEF_LOW_TIME,
   parameter int MONEY_MAX = DEF_MONEY_MAX
)(
   input logic               clk,
   input logic               resetN,
   stage_scoreboard_if.slave sb
);

   stage_state_t       state, state_nxt;
   logic               enable_d;
   logic               enable_rise;
   logic               run_active;
   logic               timer_load;
   logic               timer_tick;
   logic               timer_expire;
   logic [TIME_W-1:0]  time_left, time_left_nxt;
   logic [MONEY_W-1:0] money_q, money_nxt;
   logic [MONEY_W-1:0] target_q, target_nxt;
   logic               time_low_q, passed_q, failed_q, running_q;

   assign enable_rise = sb.enable && !enable_d;
   assign run_active  = (state == ST_RUNNING) && sb.enable && !sb.newGame;
   assign timer_load  = (state == ST_IDLE) && enable_rise && !sb.newGame;
   assign timer_tick  = run_active && sb.oneSecPulse;

   sec_countdown u_sec_countdown (
      .clk        (clk),
      .resetN     (resetN),
      .clear      (sb.newGame),
      .load       (timer_load),
      .load_value (TIME_W'(MAX_TIME)),
      .tick       (timer_tick),
      .count      (time_left),
      .count_nxt  (time_left_nxt),
      .expire     (timer_expire)
   );

   // next state, money and target; newGame overrides everything.
   // A collect in the expiring cycle is already in money_nxt when pass/fail is judged.
   always_comb begin
      state_nxt  = state;
      money_nxt  = money_q;
      target_nxt = target_q;
      if (sb.newGame) begin
         state_nxt = ST_IDLE;
         money_nxt = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (enable_rise) begin
                  state_nxt  = ST_RUNNING;
                  target_nxt = sb.targetMoney;
               end
            end
            ST_RUNNING: begin
               if (!sb.enable) begin
                  state_nxt = ST_IDLE;
               end else begin
                  if (sb.collectValid)
                     money_nxt = sat_add(money_q, sb.collectValue, MONEY_MAX);
                  if (timer_expire)
                     state_nxt = (money_nxt >= target_q) ? ST_PASSED : ST_FAILED;
               end
            end
            ST_PASSED, ST_FAILED: begin
               if (!sb.enable)
                  state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // state, accumulator and registered status outputs
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state      <= ST_IDLE;
         enable_d   <= 1'b0;
         money_q    <= '0;
         target_q   <= '0;
         time_low_q <= 1'b0;
         passed_q   <= 1'b0;
         failed_q   <= 1'b0;
         running_q  <= 1'b0;
      end else begin
         state      <= state_nxt;
         enable_d   <= sb.enable;
         money_q    <= money_nxt;
         target_q   <= target_nxt;
         running_q  <= (state_nxt == ST_RUNNING);
         time_low_q <= (state_nxt == ST_RUNNING) && (time_left_nxt <= TIME_W'(LOW_TIME));
         passed_q   <= (state == ST_RUNNING) && (state_nxt == ST_PASSED);
         failed_q   <= (state == ST_RUNNING) && (state_nxt == ST_FAILED);
      end
   end

   assign sb.timeLeft    = time_left;
   assign sb.money       = money_q;
   assign sb.timeLow     = time_low_q;
   assign sb.stagePassed = passed_q;
   assign sb.stageFailed = failed_q;
   assign sb.running     = running_q;

endmodule

// File: tb/tb_stage_scoreboard.sv
// Directed bench for stage_scoreboard: a stage-level reference model checked
// every cycle, plus hand-computed literal checkpoints.
module tb_stage_scoreboard;
   import stage_scoreboard_pkg::*;

   localparam int PH_IDLE = 0;
   localparam int PH_RUN  = 1;
   localparam int PH_PASS = 2;
   localparam int PH_FAIL = 3;

   typedef struct {
      int phase;
      int money;
      int time_left;
      int target;
      bit en_prev;
      bit passed;
      bit failed;
   } model_t;

   logic   clk    = 1'b0;
   logic   resetN = 1'b0;
   int     tests  = 0;
   int     fails  = 0;
   int     pass_seen = 0;
   int     fail_seen = 0;
   model_t mdl;

   stage_scoreboard_if sb();

   stage_scoreboard #(.MAX_TIME(60), .LOW_TIME(10), .MONEY_MAX(9999)) dut (
      .clk    (clk),
      .resetN (resetN),
      .sb     (sb)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int actual, input int expected);
      tests++;
      if (actual != expected) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   function automatic model_t model_reset();
      model_t r;
      r.phase = PH_IDLE; r.money = 0; r.time_left = 0; r.target = 0;
      r.en_prev = 1'b0; r.passed = 1'b0; r.failed = 1'b0;
      return r;
   endfunction

   // One clock of the stage rules: 60 s stage, money ceiling 9999.
   function automatic model_t model_next(model_t m, bit en, bit ng, bit sec, bit cv,
                                         int val, int tgt);
      model_t n;
      n = m;
      n.en_prev = en;
      n.passed  = 1'b0;
      n.failed  = 1'b0;
      if (ng) begin
         n.phase = PH_IDLE; n.money = 0; n.time_left = 0;
      end else if (m.phase == PH_IDLE) begin
         if (en && !m.en_prev) begin
            n.phase = PH_RUN; n.time_left = 60; n.target = tgt;
         end
      end else if (m.phase == PH_RUN) begin
         if (!en) begin
            n.phase = PH_IDLE;
         end else begin
            if (cv) n.money = (m.money + val > 9999) ? 9999 : m.money + val;
            if (sec && m.time_left == 1) begin
               n.time_left = 0;
               if (n.money >= m.target) begin n.phase = PH_PASS; n.passed = 1'b1; end
               else                     begin n.phase = PH_FAIL; n.failed = 1'b1; end
            end else if (sec && m.time_left > 0) begin
               n.time_left = m.time_left - 1;
            end
         end
      end else if (!en) begin
         n.phase = PH_IDLE;
      end
      return n;
   endfunction

   // reference model advances on the same edges as the DUT
   always @(posedge clk or negedge resetN) begin
      if (!resetN)
         mdl <= model_reset();
      else
         mdl <= model_next(mdl, sb.enable, sb.newGame, sb.oneSecPulse, sb.collectValid,
                           int'(sb.collectValue), int'(sb.targetMoney));
   end

   // every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (resetN) begin
         check("running",      int'(sb.running),     int'(mdl.phase == PH_RUN));
         check("time_left",    int'(sb.timeLeft),    mdl.time_left);
         check("money",        int'(sb.money),       mdl.money);
         check("time_low",     int'(sb.timeLow),     int'(mdl.phase == PH_RUN && mdl.time_left <= 10));
         check("stage_passed", int'(sb.stagePassed), int'(mdl.passed));
         check("stage_failed", int'(sb.stageFailed), int'(mdl.failed));
         pass_seen += int'(sb.stagePassed);
         fail_seen += int'(sb.stageFailed);
      end
   end

   task automatic step(input bit ng, input bit sec, input bit cv, input int val);
      sb.newGame      = ng;
      sb.oneSecPulse  = sec;
      sb.collectValid = cv;
      sb.collectValue = 10'(val);
      @(negedge clk);
      sb.newGame      = 1'b0;
      sb.oneSecPulse  = 1'b0;
      sb.collectValid = 1'b0;
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_time_left"}, int'(sb.timeLeft),    0);
      check({tag, "_money"},     int'(sb.money),       0);
      check({tag, "_running"},   int'(sb.running),     0);
      check({tag, "_time_low"},  int'(sb.timeLow),     0);
      check({tag, "_passed"},    int'(sb.stagePassed), 0);
      check({tag, "_failed"},    int'(sb.stageFailed), 0);
   endtask

   initial begin
      sb.enable       = 1'b0;
      sb.newGame      = 1'b0;
      sb.oneSecPulse  = 1'b0;
      sb.collectValid = 1'b0;
      sb.collectValue = '0;
      sb.targetMoney  = 14'd100;
      repeat (2) @(negedge clk);
      #1;
      check_all_zero("reset");
      resetN = 1'b1;
      step(0, 0, 0, 0);

      // full stage, no collects, target 100 -> fail
      sb.enable = 1'b1;
      step(0, 0, 0, 0);
      check("start_time", int'(sb.timeLeft), 60);
      check("start_running", int'(sb.running), 1);
      for (int i = 0; i < 50; i++) step(0, 1, 0, 0);
      check("low_edge_time", int'(sb.timeLeft), 10);
      check("low_edge_flag", int'(sb.timeLow), 1);
      for (int i = 0; i < 9; i++) step(0, 1, 0, 0);
      check("last_second", int'(sb.timeLeft), 1);
      step(0, 1, 0, 0);
      check("fail_pulse", int'(sb.stageFailed), 1);
      check("fail_time", int'(sb.timeLeft), 0);
      check("fail_money", int'(sb.money), 0);
      step(0, 0, 0, 0);
      check("fail_pulse_width", int'(sb.stageFailed), 0);
      check("fail_count", fail_seen, 1);

      // 500 + 250 against 650 -> pass
      sb.enable = 1'b0;
      step(0, 0, 0, 0);
      sb.targetMoney = 14'd650;
      sb.enable = 1'b1;
      step(0, 0, 0, 0);
      step(0, 0, 1, 500);
      step(0, 0, 1, 250);
      check("sum_750", int'(sb.money), 750);
      for (int i = 0; i < 60; i++) step(0, 1, 0, 0);
      step(0, 0, 0, 0);
      check("pass_count", pass_seen, 1);
      check("pass_money", int'(sb.money), 750);

      // collect while idle is ignored
      sb.enable = 1'b0;
      step(0, 0, 0, 0);
      step(0, 0, 1, 100);
      check("idle_collect", int'(sb.money), 750);

      // 600 then 50 on the final tick -> exactly 650, pass
      step(1, 0, 0, 0);
      check("newgame_idle_money", int'(sb.money), 0);
      sb.enable = 1'b1;
      step(0, 0, 0, 0);
      step(0, 0, 1, 600);
      for (int i = 0; i < 59; i++) step(0, 1, 0, 0);
      check("pre_final_time", int'(sb.timeLeft), 1);
      step(0, 1, 1, 50);
      check("final_collect_money", int'(sb.money), 650);
      check("final_collect_pass", int'(sb.stagePassed), 1);
      check("final_collect_time", int'(sb.timeLeft), 0);

      // saturation at 9999
      sb.enable = 1'b0;
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      sb.enable = 1'b1;
      step(0, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 1, 999);
      check("money_9990", int'(sb.money), 9990);
      step(0, 0, 1, 999);
      check("money_sat", int'(sb.money), 9999);
      step(0, 0, 1, 1023);
      check("money_sat_hold", int'(sb.money), 9999);

      // enable drops at 30 s, then a fresh start keeps money
      for (int i = 0; i < 30; i++) step(0, 1, 0, 0);
      check("abort_time", int'(sb.timeLeft), 30);
      sb.enable = 1'b0;
      step(0, 0, 0, 0);
      check("abort_running", int'(sb.running), 0);
      check("abort_time_hold", int'(sb.timeLeft), 30);
      step(0, 0, 0, 0);
      check("abort_no_pass", pass_seen, 2);
      check("abort_no_fail", fail_seen, 1);
      sb.enable = 1'b1;
      step(0, 0, 0, 0);
      check("restart_time", int'(sb.timeLeft), 60);
      check("restart_money", int'(sb.money), 9999);

      // newGame beats a simultaneous collect
      step(1, 0, 1, 100);
      check("newgame_money", int'(sb.money), 0);
      check("newgame_running", int'(sb.running), 0);
      check("newgame_time", int'(sb.timeLeft), 0);

      // reset in mid-stage clears outputs immediately
      sb.enable = 1'b0;
      step(0, 0, 0, 0);
      sb.enable = 1'b1;
      step(0, 0, 0, 0);
      step(0, 0, 1, 300);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      check("pre_reset_time", int'(sb.timeLeft), 58);
      check("pre_reset_money", int'(sb.money), 300);
      #2;
      resetN = 1'b0;
      #1;
      check_all_zero("mid_reset");
      sb.enable = 1'b0;
      @(negedge clk);
      #1;
      resetN = 1'b1;
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      check("post_reset_idle", int'(sb.running), 0);
      sb.enable = 1'b1;
      step(0, 0, 0, 0);
      check("post_reset_start", int'(sb.running), 1);
      check("post_reset_time", int'(sb.timeLeft), 60);
      step(0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/stage_scoreboard.md
STAGE_SCOREBOARD -- requirements
Module: stage_scoreboard

Interface
REQ-001 Parameter MAX_TIME, default 60: stage duration in seconds, loaded on stage start.
REQ-002 Parameter LOW_TIME, default 10: timeLow threshold in seconds.
REQ-003 Parameter MONEY_MAX, default 9999: saturation ceiling of the money accumulator.
REQ-004 clk  input  1  system clock.
REQ-005 resetN  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  stage active; its rising edge starts a stage.
REQ-007 newGame  input  1  one-cycle pulse that clears money and returns the block to IDLE.
REQ-008 oneSecPulse  input  1  one-cycle tick per second.
REQ-009 collectValid  input  1  one-cycle pulse meaning a grabbed object reached the hook origin.
REQ-010 collectValue  input  10  binary value of the collected object.
REQ-011 targetMoney  input  14  money goal for the stage, sampled on stage start.
REQ-012 timeLeft  output  7  remaining seconds.
REQ-013 money  output  14  accumulated money.
REQ-014 timeLow  output  1  high while RUNNING and timeLeft <= LOW_TIME.
REQ-015 stagePassed  output  1  one-cycle pulse.
REQ-016 stageFailed  output  1  one-cycle pulse.
REQ-017 running  output  1  high in RUNNING.

Function
REQ-018 The FSM SHALL have the states IDLE, RUNNING, PASSED and FAILED.
REQ-019 IDLE->RUNNING on the cycle after an enable rising edge is detected via a registered enable_d: timeLeft<=MAX_TIME, target register<=targetMoney, money unchanged.
REQ-020 In RUNNING, each oneSecPulse SHALL decrement timeLeft by 1; timeLeft never wraps below 0.
REQ-021 In RUNNING, a collectValid pulse SHALL add collectValue to money, saturating at MONEY_MAX; collects outside RUNNING are ignored.
REQ-022 A oneSecPulse arriving while timeLeft==1 ends the stage: next state PASSED if the post-collect money >= target, else FAILED; timeLeft becomes 0.
REQ-023 If collectValid and the final oneSecPulse fall in the same cycle, the collected value SHALL be included in both money and the pass/fail comparison.
REQ-024 stagePassed or stageFailed SHALL assert for exactly the one cycle following entry into PASSED or FAILED; the two are never high together.
REQ-025 PASSED and FAILED SHALL hold timeLeft and money, and return to IDLE when enable is low.
REQ-026 If enable falls while RUNNING, the FSM SHALL go to IDLE next cycle with no pass/fail pulse, and money is retained.
REQ-027 newGame SHALL have priority over every other event: next cycle money=0, timeLeft=0, state=IDLE, no pulses.
REQ-028 An enable rising edge in PASSED or FAILED SHALL be ignored until IDLE is reached.
REQ-029 Output latency SHALL be one clock from the causing input; all outputs are registered.
REQ-030 Arithmetic SHALL be unsigned; the sum is computed at 15 bits before saturation.

Reset
REQ-031 Asserting resetN SHALL immediately force state=IDLE, timeLeft=0, money=0, target=0, enable_d=0, and all 1-bit outputs=0.
REQ-032 Reset in mid-stage SHALL discard the stage with no pulse; after release, a new enable rising edge is required to start a stage.

Structure
REQ-033 The state enum and the MAX_TIME, LOW_TIME and MONEY_MAX defaults SHALL live in the shared game package, which LevelController also uses.
REQ-034 The second countdown SHALL be a sub-module sec_countdown (load, tick, 7-bit count, expire pulse); the FSM and accumulator live in the top level.

Verification
REQ-035 Reset, then enable rises and 60 oneSecPulses are applied with no collects, targetMoney=100 -> timeLeft 60..0, one stageFailed pulse, money=0.
REQ-036 Collects of 500 and 250, targetMoney=650, time runs out -> money=750 and exactly one stagePassed pulse.
REQ-037 money=600, target=650, collect of 50 in the same cycle as the final tick -> money=650 and stagePassed.
REQ-038 money=9990 and a collect of 999 -> money=9999; a collect while IDLE -> money unchanged.
REQ-039 enable falls at timeLeft=30 -> IDLE with no pulse; the next enable rising edge reloads timeLeft=60 and keeps money.
REQ-040 newGame in the same cycle as collectValid in RUNNING -> money=0 and IDLE; resetN asserted in mid-stage -> all outputs 0 immediately.
